tick_divider_mc: RTL

TICK_DIVIDER_MC -- requirements
Module: tick_divider_mc

---
 rtl/tick_divider_mc_pkg.sv | 19 +
 rtl/tick_divider_ch.sv | 67 ++++++
 rtl/tick_divider_mc.sv | 60 ++++++
 3 files changed

// File: rtl/tick_divider_mc_pkg.sv
// Shared constants for the multi-channel tick divider: output modes and
// default parameter values used by the top and the per-channel counter.
package tick_divider_mc_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } tick_mode_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 21;
  localparam int unsigned DEF_DIV    = 500_000;

  // Width of a channel index; a single channel still needs a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider_ch.sv
// One divider channel: free-running modulo-div counter with a registered
// pulse or square-wave output and a single-cycle divisor load.
module tick_divider_ch
  import tick_divider_mc_pkg::*;
#(
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_div_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             mode_q, mode_d;
  logic             tc;

  // div is never 0, so div-1 cannot underflow.
  assign tc = (cnt_q == (div_q - CNT_W'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = tick_q;
    mode_d = mode_i;
    if (load_i) begin
      div_d  = load_div_i;
      cnt_d  = '0;
      tick_d = 1'b0;
    end else begin
      if (en_i) begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
      end
      if (mode_i != mode_q) begin
        tick_d = 1'b0;
      end else if (mode_i == MODE_PULSE) begin
        tick_d = en_i && tc;
      end else if (en_i && tc) begin
        tick_d = ~tick_q;
      end
    end
  end

  // mode_q follows the input during reset so a static mode is not seen as a change.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= DEFAULT_DIV;
      tick_q <= 1'b0;
      mode_q <= mode_i;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tick_divider_mc.sv
// Multi-channel tick divider: NUM_CH independent channels sharing one
// divisor-load port with registered accept/reject handshake pulses.
module tick_divider_mc
  import tick_divider_mc_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             mode,
  input  logic                          load,
  input  logic [ch_idx_w(NUM_CH)-1:0]   load_ch,
  input  logic [CNT_W-1:0]              load_div,
  output logic                          load_ack,
  output logic                          load_err,
  output logic [NUM_CH-1:0]             tick
);

  logic load_ok;
  logic load_ack_q, load_ack_d;
  logic load_err_q, load_err_d;

  always_comb begin
    load_ok    = load && (32'(load_ch) < NUM_CH) && (load_div != '0);
    load_ack_d = load_ok;
    load_err_d = load && !load_ok;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      load_ack_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_ack_q <= load_ack_d;
      load_err_q <= load_err_d;
    end
  end

  assign load_ack = load_ack_q;
  assign load_err = load_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_divider_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clkin     (clkin),
      .rst       (rst),
      .en_i      (en[g]),
      .mode_i    (mode[g]),
      .load_i    (load_ok && (32'(load_ch) == g)),
      .load_div_i(load_div),
      .tick_o    (tick[g])
    );
  end

endmodule
